alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the existing ALU's operand, control and shamt inputs.
- Decodes ALUOp/funct into the 4-bit ALU control code and registers the decoded instruction.
- Resolves EX/MEM and MEM/WB forwarding onto the ALU operands.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, register-file index width
- CTRL_W, 4, ALU control code width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_alu_op  input  2  00 add (lw/sw), 01 sub (beq), 10 R-type by funct, 11 or (ori)
- id_funct  input  6  instruction funct field
- id_shamt  input  5  shift amount
- id_rs_data, id_rt_data  input  DATA_W  register-file read data
- id_imm  input  DATA_W  extended immediate
- id_alu_src  input  1  1: operand B is immediate
- id_reg_dst  input  1  1: destination is rd, else rt
- id_reg_write, id_mem_read, id_mem_write  input  1  control bits carried to EX
- id_rs, id_rt, id_rd  input  REG_ADDR_W  register indices
- stall_in  input  1  downstream hold
- flush  input  1  squash ID instruction (branch taken)
- ex_mem_reg_write  input  1  forwarding source 1 write-enable
- ex_mem_rd  input  REG_ADDR_W  forwarding source 1 destination
- ex_mem_result  input  DATA_W  forwarding source 1 data
- mem_wb_reg_write  input  1  forwarding source 2 write-enable
- mem_wb_rd  input  REG_ADDR_W  forwarding source 2 destination
- mem_wb_result  input  DATA_W  forwarding source 2 data
- ALU_reg_1, ALU_reg_2  output  DATA_W  ALU operands
- ALU_control  output  CTRL_W  ALU operation code
- shamt  output  5  ALU shift amount
- ex_store_data  output  DATA_W  forwarded rt value for sw
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1  registered control bits
- ex_dest  output  REG_ADDR_W  destination index
- ex_illegal  output  1  R-type with unsupported funct
- stall_out  output  1  load-use stall request to PC/IF-ID (combinational)

Behaviour:
- Control codes (fixed): AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1111.
- ALUOp 00 gives ADD; 01 gives SUB; 11 gives OR.
- ALUOp 10 decodes funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL.
- Any other funct under ALUOp 10 gives ADD with ex_illegal=1.
- Reset (async, reset_n=0): all registered state clears to 0. ALU_control=0000, operands 0, every ex_* output 0.
- Load-use hazard (combinational) = ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | (ex_dest==id_rt & !id_alu_src)).
- stall_out = hazard.
- Per-edge priority is flush > stall_in > hazard > capture:
  - flush: bubble. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal all 0; data fields don't-care, zeroed.
  - stall_in: hold all registers unchanged.
  - hazard: bubble, as for flush.
  - capture: latch all id_* fields, the decoded code and ex_dest=(id_reg_dst?id_rd:id_rt).
- id_valid=0 at capture loads a bubble.
- Latency: one cycle from ID to EX outputs. A load-use pair gets exactly one bubble.
- Forwarding (combinational from registered rs/rt indices):
  - fwdA = ex_mem_result if ex_mem_reg_write & ex_mem_rd!=0 & ex_mem_rd==ex_rs.
  - Otherwise fwdA = mem_wb_result under the same test on MEM/WB.
  - Otherwise fwdA = registered rs_data.
  - fwdB is identical on rt.
  - EX/MEM wins when both sources match. Register 0 is never forwarded.
- Operand outputs: ALU_reg_1=fwdA; ALU_reg_2 = alu_src ? imm : fwdB; ex_store_data=fwdB.
- ALU_control and shamt come directly from registers.
- Reset mid-stream discards the in-flight instruction. The first edge after reset release captures normally.

Decomposition:
- Package mips_pkg holds:
  - ALU control code constants
  - ALUOp encodings
  - funct constants
- Combinational sub-module alu_ctrl_decode maps (alu_op, funct) to (code, illegal). It is instantiated before the pipeline register.

Test Plan:
- Reset: reset_n low mid-cycle, outputs go to zero immediately (ALU_control=0000, ex_valid=0). Release, then add r3=r1+r2 (funct 100000): next cycle ALU_control=0010 and ex_dest=3.
- Decode sweep: each supported funct and ALUOp 00/01/11 gives the listed code. funct 001000 under ALUOp 10 gives 0010 with ex_illegal=1.
- Forwarding: EX/MEM rd=5 with 0x10, MEM/WB rd=5 with 0x20, ex_rs=5 gives ALU_reg_1=0x10. rd=0 with reg_write=1 gives register-file data.
- Load-use: lw r4 in EX, then add r6,r4,r1 in ID gives stall_out=1 for one cycle and a bubble (ex_valid=0). Next cycle add is captured and ALU_reg_1 is forwarded from MEM/WB.
- flush with stall_in and hazard all asserted: bubble loaded. stall_in alone: outputs held for 3 cycles, then capture resumes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the ALU issue (ID/EX) stage:
// ALU control codes, ALUOp encodings, funct values and the EX register layout.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 4;
    localparam int SHAMT_W    = 5;

    // Operation codes understood by the downstream ALU.
    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_SLL = 4'b1111
    } alu_ctrl_e;

    // Main-decoder ALUOp field.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,  // lw / sw address
        ALUOP_SUB   = 2'b01,  // beq compare
        ALUOP_RTYPE = 2'b10,  // operation taken from funct
        ALUOP_OR    = 2'b11   // ori
    } alu_op_e;

    // R-type funct values that the ALU supports.
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;

    // Contents of the ID/EX pipeline register. An all-zero value is a bubble.
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
        logic                  alu_src;
        logic [CTRL_W-1:0]     ctrl;
        logic [SHAMT_W-1:0]    shamt;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
    } ex_reg_t;

    // A later stage can supply a register value only if it writes a
    // non-zero destination equal to the requested index.
    function automatic logic fwd_hit(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] idx
    );
        return we && (rd != '0) && (rd == idx);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Signal bundle between the ID stage / forwarding network and the issue stage.
// Bus semantics: there is no valid/ready pair here. id_valid qualifies the ID
// fields; stall_in holds the EX register; flush squashes the ID instruction;
// stall_out asks PC and IF/ID to hold for one cycle on a load-use hazard.
interface alu_issue_stage_if;
    import mips_pkg::*;

    // ID-stage instruction
    logic                  id_valid;
    logic [1:0]            id_alu_op;
    logic [5:0]            id_funct;
    logic [SHAMT_W-1:0]    id_shamt;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_alu_src;
    logic                  id_reg_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;

    // Pipeline control
    logic                  stall_in;
    logic                  flush;

    // Forwarding sources
    logic                  ex_mem_reg_write;
    logic [REG_ADDR_W-1:0] ex_mem_rd;
    logic [DATA_W-1:0]     ex_mem_result;
    logic                  mem_wb_reg_write;
    logic [REG_ADDR_W-1:0] mem_wb_rd;
    logic [DATA_W-1:0]     mem_wb_result;

    // EX-stage outputs
    logic [DATA_W-1:0]     ALU_reg_1;
    logic [DATA_W-1:0]     ALU_reg_2;
    logic [CTRL_W-1:0]     ALU_control;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_W-1:0]     ex_store_data;
    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_illegal;
    logic                  stall_out;

    // Driver side: ID stage, hazard/forwarding network
    modport master (
        output id_valid, id_alu_op, id_funct, id_shamt, id_rs_data, id_rt_data,
               id_imm, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_rs, id_rt, id_rd, stall_in, flush,
               ex_mem_reg_write, ex_mem_rd, ex_mem_result,
               mem_wb_reg_write, mem_wb_rd, mem_wb_result,
        input  ALU_reg_1, ALU_reg_2, ALU_control, shamt, ex_store_data,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_dest,
               ex_illegal, stall_out
    );

    // Issue-stage side
    modport slave (
        input  id_valid, id_alu_op, id_funct, id_shamt, id_rs_data, id_rt_data,
               id_imm, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_rs, id_rt, id_rd, stall_in, flush,
               ex_mem_reg_write, ex_mem_rd, ex_mem_result,
               mem_wb_reg_write, mem_wb_rd, mem_wb_result,
        output ALU_reg_1, ALU_reg_2, ALU_control, shamt, ex_store_data,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_dest,
               ex_illegal, stall_out
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder: (ALUOp, funct) -> 4-bit ALU code.
// Unsupported R-type funct values fall back to ADD and raise o_illegal.
module alu_ctrl_decode
    import mips_pkg::*;
(
    input  logic [1:0]        i_alu_op,
    input  logic [5:0]        i_funct,
    output logic [CTRL_W-1:0] o_code,
    output logic              o_illegal
);

    // Map ALUOp first; only R-type consults funct.
    always_comb begin
        o_code    = ALU_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_code = ALU_ADD;
            ALUOP_SUB: o_code = ALU_SUB;
            ALUOP_OR:  o_code = ALU_OR;
            default: begin
                case (i_funct)
                    FUNCT_ADD: o_code = ALU_ADD;
                    FUNCT_SUB: o_code = ALU_SUB;
                    FUNCT_AND: o_code = ALU_AND;
                    FUNCT_OR:  o_code = ALU_OR;
                    FUNCT_NOR: o_code = ALU_NOR;
                    FUNCT_SLT: o_code = ALU_SLT;
                    FUNCT_SLL: o_code = ALU_SLL;
                    default: begin
                        o_code    = ALU_ADD;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ALU operation, registers the instruction,
// inserts one bubble per load-use hazard and forwards EX/MEM and MEM/WB
// results onto the ALU operands.
module alu_issue_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    alu_issue_stage_if.slave bus
);

    logic [CTRL_W-1:0] w_code;
    logic              w_illegal;
    logic              w_hazard;
    ex_reg_t           w_capture;
    ex_reg_t           r_ex;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    alu_ctrl_decode u_decode (
        .i_alu_op  (bus.id_alu_op),
        .i_funct   (bus.id_funct),
        .o_code    (w_code),
        .o_illegal (w_illegal)
    );

    // Load in EX whose destination is read by the ID instruction. rt counts
    // only when it is actually used as operand B (not replaced by imm).
    always_comb begin
        w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.dest != '0) &&
                   bus.id_valid &&
                   ((r_ex.dest == bus.id_rs) ||
                    ((r_ex.dest == bus.id_rt) && !bus.id_alu_src));
    end

    // Register image of the ID instruction; id_valid=0 yields a bubble.
    always_comb begin
        w_capture = '0;
        if (bus.id_valid) begin
            w_capture.valid     = 1'b1;
            w_capture.reg_write = bus.id_reg_write;
            w_capture.mem_read  = bus.id_mem_read;
            w_capture.mem_write = bus.id_mem_write;
            w_capture.illegal   = w_illegal;
            w_capture.alu_src   = bus.id_alu_src;
            w_capture.ctrl      = w_code;
            w_capture.shamt     = bus.id_shamt;
            w_capture.rs        = bus.id_rs;
            w_capture.rt        = bus.id_rt;
            w_capture.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            w_capture.rs_data   = bus.id_rs_data;
            w_capture.rt_data   = bus.id_rt_data;
            w_capture.imm       = bus.id_imm;
        end
    end

    // Pipeline register, priority flush > stall_in > hazard > capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex <= '0;
        end else if (bus.flush) begin
            r_ex <= '0;
        end else if (bus.stall_in) begin
            r_ex <= r_ex;
        end else if (w_hazard) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_capture;
        end
    end

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        if (fwd_hit(bus.ex_mem_reg_write, bus.ex_mem_rd, r_ex.rs)) begin
            w_fwd_a = bus.ex_mem_result;
        end else if (fwd_hit(bus.mem_wb_reg_write, bus.mem_wb_rd, r_ex.rs)) begin
            w_fwd_a = bus.mem_wb_result;
        end else begin
            w_fwd_a = r_ex.rs_data;
        end

        if (fwd_hit(bus.ex_mem_reg_write, bus.ex_mem_rd, r_ex.rt)) begin
            w_fwd_b = bus.ex_mem_result;
        end else if (fwd_hit(bus.mem_wb_reg_write, bus.mem_wb_rd, r_ex.rt)) begin
            w_fwd_b = bus.mem_wb_result;
        end else begin
            w_fwd_b = r_ex.rt_data;
        end
    end

    assign bus.stall_out     = w_hazard;
    assign bus.ALU_reg_1     = w_fwd_a;
    assign bus.ALU_reg_2     = r_ex.alu_src ? r_ex.imm : w_fwd_b;
    assign bus.ex_store_data = w_fwd_b;
    assign bus.ALU_control   = r_ex.ctrl;
    assign bus.shamt         = r_ex.shamt;
    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_dest       = r_ex.dest;
    assign bus.ex_illegal    = r_ex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// compared against an instruction-level reference model.
module tb_alu_issue_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference view of the instruction currently sitting in EX.
    typedef struct {
        logic        v, rw, mr, mw, ill, src;
        logic [3:0]  ctrl;
        logic [4:0]  shamt, rs, rt, dest;
        logic [31:0] rsd, rtd, imm;
    } ex_t;

    ex_t m;

    logic [5:0] sweep_funct [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                    6'b100111, 6'b101010, 6'b000000};
    logic [3:0] sweep_code  [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                    4'b1100, 4'b0111, 4'b1111};

    function automatic ex_t bubble();
        ex_t b;
        b = '{default: '0};
        return b;
    endfunction

    // ALU code table as written in the instruction-set description.
    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                      output logic [3:0] code, output logic ill);
        ill = 1'b0;
        code = 4'b0010;
        case (op)
            2'b00: code = 4'b0010;
            2'b01: code = 4'b0110;
            2'b11: code = 4'b0001;
            default: begin
                case (f)
                    6'b100000: code = 4'b0010;
                    6'b100010: code = 4'b0110;
                    6'b100100: code = 4'b0000;
                    6'b100101: code = 4'b0001;
                    6'b100111: code = 4'b1100;
                    6'b101010: code = 4'b0111;
                    6'b000000: code = 4'b1111;
                    default: begin code = 4'b0010; ill = 1'b1; end
                endcase
            end
        endcase
    endfunction

    function automatic logic model_hazard();
        return m.v && m.mr && (m.dest != 0) && bus.id_valid &&
               ((m.dest == bus.id_rs) || ((m.dest == bus.id_rt) && !bus.id_alu_src));
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] regval);
        if (bus.ex_mem_reg_write && bus.ex_mem_rd != 0 && bus.ex_mem_rd == idx)
            return bus.ex_mem_result;
        if (bus.mem_wb_reg_write && bus.mem_wb_rd != 0 && bus.mem_wb_rd == idx)
            return bus.mem_wb_result;
        return regval;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] fb;
        fb = ref_fwd(m.rt, m.rtd);
        check("alu_reg_1",     bus.ALU_reg_1, ref_fwd(m.rs, m.rsd));
        check("alu_reg_2",     bus.ALU_reg_2, m.src ? m.imm : fb);
        check("ex_store_data", bus.ex_store_data, fb);
        check("alu_control",   32'(bus.ALU_control), 32'(m.ctrl));
        check("shamt",         32'(bus.shamt), 32'(m.shamt));
        check("ex_valid",      32'(bus.ex_valid), 32'(m.v));
        check("ex_reg_write",  32'(bus.ex_reg_write), 32'(m.rw));
        check("ex_mem_read",   32'(bus.ex_mem_read), 32'(m.mr));
        check("ex_mem_write",  32'(bus.ex_mem_write), 32'(m.mw));
        check("ex_dest",       32'(bus.ex_dest), 32'(m.dest));
        check("ex_illegal",    32'(bus.ex_illegal), 32'(m.ill));
    endtask

    // One clock: check stall_out, advance the model by the per-edge rules,
    // then compare all EX outputs after the edge.
    task automatic step();
        ex_t nxt;
        logic haz;
        logic [3:0] code;
        logic ill;
        #1;
        haz = model_hazard();
        check("stall_out", 32'(bus.stall_out), 32'(haz));
        if (bus.flush) nxt = bubble();
        else if (bus.stall_in) nxt = m;
        else if (haz || !bus.id_valid) nxt = bubble();
        else begin
            ref_decode(bus.id_alu_op, bus.id_funct, code, ill);
            nxt.v = 1'b1; nxt.rw = bus.id_reg_write; nxt.mr = bus.id_mem_read;
            nxt.mw = bus.id_mem_write; nxt.ill = ill; nxt.src = bus.id_alu_src;
            nxt.ctrl = code; nxt.shamt = bus.id_shamt;
            nxt.rs = bus.id_rs; nxt.rt = bus.id_rt;
            nxt.dest = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            nxt.rsd = bus.id_rs_data; nxt.rtd = bus.id_rt_data; nxt.imm = bus.id_imm;
        end
        @(posedge clk);
        #1;
        m = nxt;
        check_outputs();
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_alu_op = 0; bus.id_funct = 0; bus.id_shamt = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
        bus.id_alu_src = 0; bus.id_reg_dst = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.stall_in = 0; bus.flush = 0;
        bus.ex_mem_reg_write = 0; bus.ex_mem_rd = 0; bus.ex_mem_result = 0;
        bus.mem_wb_reg_write = 0; bus.mem_wb_rd = 0; bus.mem_wb_result = 0;
    endtask

    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [5:0] f, input logic [31:0] rsd, input logic [31:0] rtd);
        bus.id_valid = 1; bus.id_alu_op = 2'b10; bus.id_funct = f;
        bus.id_shamt = 5'($urandom); bus.id_imm = $urandom;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd;
        bus.id_alu_src = 0; bus.id_reg_dst = 1;
        bus.id_reg_write = 1; bus.id_mem_read = 0; bus.id_mem_write = 0;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        bus.id_valid = 1; bus.id_alu_op = 2'b00; bus.id_funct = 6'($urandom);
        bus.id_shamt = 0; bus.id_imm = imm;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = 5'($urandom);
        bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
        bus.id_alu_src = 1; bus.id_reg_dst = 0;
        bus.id_reg_write = 1; bus.id_mem_read = 1; bus.id_mem_write = 0;
    endtask

    task automatic rand_inputs();
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.id_alu_op = 2'($urandom_range(0, 3));
        bus.id_funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : sweep_funct[$urandom_range(0, 6)];
        bus.id_shamt = 5'($urandom);
        bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
        bus.id_alu_src = 1'($urandom_range(0, 1));
        bus.id_reg_dst = 1'($urandom_range(0, 1));
        bus.id_reg_write = 1'($urandom_range(0, 1));
        bus.id_mem_read = ($urandom_range(0, 2) == 0);
        bus.id_mem_write = 1'($urandom_range(0, 1));
        bus.id_rs = 5'($urandom_range(0, 7));
        bus.id_rt = 5'($urandom_range(0, 7));
        bus.id_rd = 5'($urandom_range(0, 7));
        bus.stall_in = ($urandom_range(0, 7) == 0);
        bus.flush = ($urandom_range(0, 9) == 0);
        bus.ex_mem_reg_write = 1'($urandom_range(0, 1));
        bus.ex_mem_rd = 5'($urandom_range(0, 7));
        bus.ex_mem_result = $urandom;
        bus.mem_wb_reg_write = 1'($urandom_range(0, 1));
        bus.mem_wb_rd = 5'($urandom_range(0, 7));
        bus.mem_wb_result = $urandom;
    endtask

    initial begin
        // Power-on reset
        idle();
        m = bubble();
        #1;
        check_outputs();
        #7 reset_n = 1'b1;

        // Two real instructions, then a reset asserted mid-cycle
        set_rtype(1, 2, 7, 6'b100010, 32'h11, 32'h22); step();
        set_lw(3, 9, 32'h40); step();
        #3 reset_n = 1'b0;
        #1;
        m = bubble();
        check_outputs();
        check("rst_alu_control", 32'(bus.ALU_control), 32'h0);
        check("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // add r3 = r1 + r2 right after release
        set_rtype(1, 2, 3, 6'b100000, 32'h5, 32'h7); step();
        check("add_alu_control", 32'(bus.ALU_control), 32'h2);
        check("add_ex_dest", 32'(bus.ex_dest), 32'd3);

        // Decode sweep
        for (int i = 0; i < 7; i++) begin
            set_rtype(1, 2, 3, sweep_funct[i], $urandom, $urandom); step();
            check("sweep_code", 32'(bus.ALU_control), 32'(sweep_code[i]));
        end
        bus.id_alu_op = 2'b00; step(); check("op00_code", 32'(bus.ALU_control), 32'h2);
        bus.id_alu_op = 2'b01; step(); check("op01_code", 32'(bus.ALU_control), 32'h6);
        bus.id_alu_op = 2'b11; step(); check("op11_code", 32'(bus.ALU_control), 32'h1);
        set_rtype(1, 2, 3, 6'b001000, 32'h1, 32'h2); step();
        check("illegal_code", 32'(bus.ALU_control), 32'h2);
        check("illegal_flag", 32'(bus.ex_illegal), 32'h1);

        // Forwarding priority and register-0 exclusion
        set_rtype(5, 6, 7, 6'b100000, 32'hAAAA, 32'hBBBB); step();
        bus.ex_mem_reg_write = 1; bus.ex_mem_rd = 5; bus.ex_mem_result = 32'h10;
        bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 5; bus.mem_wb_result = 32'h20;
        #1; check_outputs();
        check("fwd_exmem_wins", bus.ALU_reg_1, 32'h10);
        bus.ex_mem_reg_write = 0;
        #1; check_outputs();
        check("fwd_memwb", bus.ALU_reg_1, 32'h20);
        bus.ex_mem_reg_write = 1; bus.ex_mem_rd = 0;
        bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 0;
        set_rtype(0, 6, 7, 6'b100000, 32'h1234, 32'h5678); step();
        check("fwd_r0_blocked", bus.ALU_reg_1, 32'h1234);

        // Load-use: exactly one bubble, then MEM/WB forwarding
        idle();
        set_lw(1, 4, 32'h8); step();
        set_rtype(4, 1, 6, 6'b100000, 32'h0, 32'h3);
        #1; check("lu_stall_out", 32'(bus.stall_out), 32'h1);
        step();
        check("lu_bubble", 32'(bus.ex_valid), 32'h0);
        bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 4; bus.mem_wb_result = 32'hCAFE;
        step();
        check("lu_capture", 32'(bus.ex_valid), 32'h1);
        check("lu_fwd", bus.ALU_reg_1, 32'hCAFE);

        // flush wins over stall_in and hazard
        idle();
        set_lw(1, 4, 32'h8); step();
        set_rtype(4, 1, 6, 6'b100000, 32'h0, 32'h3);
        bus.stall_in = 1; bus.flush = 1; step();
        check("flush_bubble", 32'(bus.ex_valid), 32'h0);

        // stall_in alone holds for three cycles
        idle();
        set_rtype(2, 3, 8, 6'b100010, 32'h9, 32'h4); step();
        set_rtype(9, 10, 11, 6'b100100, 32'h1, 32'h2);
        bus.stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", 32'(bus.ex_dest), 32'd8);
        end
        bus.stall_in = 0; step();
        check("stall_resume", 32'(bus.ex_dest), 32'd11);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
